word_slide_render: RTL and testbench

- Downstream consumer of the 32x64 word-bitmap ROM ("BY" banner).
- Takes VGA pixel coordinates from the sync generator, registers the ROM row address, and samples the returned row to drive banner pixels.
- Animates the banner: it slides in horizontally one step per frame, holds, then reports done to the game FSM.
- Sits between the VGA sync and the final RGB mux.

---
 rtl/word_slide_render_if.sv | 25 ++
 rtl/word_slide_render.sv | 172 +++++++++++++++++
 tb/tb_word_slide_render.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/word_slide_render_if.sv
// Pixel-scan and bitmap-ROM bundle shared by the sync generator, word ROM,
// banner renderer and final RGB mux.
interface word_slide_render_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [4:0]  drom_addr_num;
  logic [0:63] drom_data_num;
  logic        hsync_out;
  logic        vsync_out;
  logic [11:0] rgb_out;
  logic        text_on;

  modport master (
    output pixel_x, pixel_y, video_on, hsync_in, vsync_in, drom_data_num,
    input  drom_addr_num, hsync_out, vsync_out, rgb_out, text_on
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, hsync_in, vsync_in, drom_data_num,
    output drom_addr_num, hsync_out, vsync_out, rgb_out, text_on
  );
endinterface

// File: rtl/word_slide_render.sv
// Sliding "BY" banner renderer: pixel -> rgb/text_on/syncs in 2 cycles, no backpressure.
// Optional hold-phase blinking is enabled by defining WORD_SLIDE_BLINK_EN.
module word_slide_render #(
  parameter int          START_X     = 0,
  parameter int          TARGET_X    = 288,
  parameter int          POS_Y       = 224,
  parameter int          SLIDE_STEP  = 8,
  parameter int          HOLD_FRAMES = 120,
  parameter int          V_ACTIVE    = 480,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  word_slide_render_if.slave vid,
  output logic               busy,
  output logic               done
);
  localparam logic [9:0]  START_POS  = 10'(START_X);
  localparam logic [9:0]  TARGET_POS = 10'(TARGET_X);
  localparam logic [10:0] POS_Y_W    = 11'(POS_Y);
  localparam logic [10:0] STEP_W     = 11'(SLIDE_STEP);
  localparam int          HCW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SLIDE, S_HOLD} state_e;

  state_e         state_q, state_d;
  logic [9:0]     pos_x_q, pos_x_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic           frame_tick;
  logic           visible;
  logic [10:0]    slide_sum;
`ifdef WORD_SLIDE_BLINK_EN
  logic [4:0]     blink_cnt_q, blink_cnt_d;
  logic           blink_phase;
  assign blink_phase = ~blink_cnt_q[4];
`endif

  // Ticks once per frame, inside vertical blanking, so pos_x never tears.
  assign frame_tick = (vid.pixel_y == 10'(V_ACTIVE)) && (vid.pixel_x == 10'd0);
  assign slide_sum  = {1'b0, pos_x_q} + STEP_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pos_x_q     <= START_POS;
      hold_cnt_q  <= '0;
`ifdef WORD_SLIDE_BLINK_EN
      blink_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef WORD_SLIDE_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    hold_cnt_d  = hold_cnt_q;
`ifdef WORD_SLIDE_BLINK_EN
    blink_cnt_d = blink_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        pos_x_d = START_POS;
        if (start) state_d = S_SLIDE;
      end
      S_SLIDE: begin
        if (frame_tick) begin
          if (slide_sum >= {1'b0, TARGET_POS}) begin
            pos_x_d     = TARGET_POS;
            hold_cnt_d  = '0;
`ifdef WORD_SLIDE_BLINK_EN
            blink_cnt_d = '0;
`endif
            state_d     = S_HOLD;
          end else begin
            pos_x_d = slide_sum[9:0];
          end
        end
      end
      S_HOLD: begin
        if (frame_tick) begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
`ifdef WORD_SLIDE_BLINK_EN
          blink_cnt_d = blink_cnt_q + 1'b1;
`endif
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
            pos_x_d = START_POS;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_x_d = START_POS;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_HOLD) && frame_tick && (hold_cnt_q == HOLD_LAST);
`ifdef WORD_SLIDE_BLINK_EN
    visible = (state_q == S_SLIDE) || ((state_q == S_HOLD) && blink_phase);
`else
    visible = (state_q != S_IDLE);
`endif
  end

  // Stage 0: box test in 11 bits so pos_x+64 cannot wrap.
  logic [10:0] px, py, pos;
  logic        in_box_d;
  logic [4:0]  addr_d;
  logic [5:0]  col_d;

  assign px       = {1'b0, vid.pixel_x};
  assign py       = {1'b0, vid.pixel_y};
  assign pos      = {1'b0, pos_x_q};
  assign in_box_d = (px >= pos) && (px < pos + 11'd64) &&
                    (py >= POS_Y_W) && (py < POS_Y_W + 11'd32);
  assign addr_d   = in_box_d ? 5'(py - POS_Y_W) : 5'd0;
  assign col_d    = 6'(px - pos);

  logic [4:0]  addr_q;
  logic [5:0]  col_q;
  logic        in_box_q;
  logic        video_on_q;
  logic [1:0]  hs_q, vs_q;
  logic        text_on_q;
  logic [11:0] rgb_q;
  logic        lit_d;
  logic [11:0] rgb_d;

  assign lit_d = in_box_q && vid.drom_data_num[col_q] && visible && video_on_q;
  assign rgb_d = lit_d ? FG_COLOR : (video_on_q ? BG_COLOR : 12'h000);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      col_q      <= '0;
      in_box_q   <= 1'b0;
      video_on_q <= 1'b0;
      hs_q       <= '0;
      vs_q       <= '0;
      text_on_q  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      col_q      <= col_d;
      in_box_q   <= in_box_d;
      video_on_q <= vid.video_on;
      hs_q       <= {hs_q[0], vid.hsync_in};
      vs_q       <= {vs_q[0], vid.vsync_in};
      text_on_q  <= lit_d;
      rgb_q      <= rgb_d;
    end
  end

  assign vid.drom_addr_num = addr_q;
  assign vid.hsync_out     = hs_q[1];
  assign vid.vsync_out     = vs_q[1];
  assign vid.text_on       = text_on_q;
  assign vid.rgb_out       = rgb_q;
endmodule

// File: tb/tb_word_slide_render.sv
// Directed + randomized bench for word_slide_render against a frame-level model.
module tb_word_slide_render;
  localparam int          START_X     = 0;
  localparam int          TARGET_X    = 288;
  localparam int          POS_Y       = 224;
  localparam int          SLIDE_STEP  = 8;
  localparam int          HOLD_FRAMES = 120;
  localparam int          V_ACTIVE    = 480;
  localparam logic [11:0] FG          = 12'hFFF;
  localparam logic [11:0] BG          = 12'h000;

  logic clk = 1'b0;
  logic reset, start, busy, done;
  logic [0:63] rom [32];

  word_slide_render_if vid();
  assign vid.drom_data_num = rom[vid.drom_addr_num];

  word_slide_render #(
    .START_X(START_X), .TARGET_X(TARGET_X), .POS_Y(POS_Y), .SLIDE_STEP(SLIDE_STEP),
    .HOLD_FRAMES(HOLD_FRAMES), .V_ACTIVE(V_ACTIVE), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .vid(vid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp, n_bad;
  // Model: animation phase (0 idle, 1 slide, 2 hold), left edge, frames held.
  int m_state, m_pos, m_hold;
  bit p0_in, p0_von, p0_hs, p0_vs;
  int p0_addr, p0_col;
  bit p1_text, p1_hs, p1_vs;
  logic [11:0] p1_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_visible();
    if (m_state == 0) return 1'b0;
`ifdef WORD_SLIDE_BLINK_EN
    if (m_state == 2) return ((m_hold / 16) % 2) == 0;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pos = START_X; m_hold = 0;
    p0_in = 0; p0_von = 0; p0_hs = 0; p0_vs = 0; p0_addr = 0; p0_col = 0;
    p1_text = 0; p1_hs = 0; p1_vs = 0; p1_rgb = '0;
  endtask

  task automatic cyc(input int x, input int y, input bit von, input bit hs, input bit vs,
                     input bit st, input bit rst);
    bit tick, lit;
    @(negedge clk);
    vid.pixel_x = 10'(x); vid.pixel_y = 10'(y); vid.video_on = von;
    vid.hsync_in = hs; vid.vsync_in = vs; start = st; reset = rst;
    #1;
    tick = (x == 0) && (y == V_ACTIVE);
    check("drom_addr_num", 32'(vid.drom_addr_num), 32'(p0_addr));
    check("text_on", 32'(vid.text_on), 32'(p1_text));
    check("rgb_out", 32'(vid.rgb_out), 32'(p1_rgb));
    check("hsync_out", 32'(vid.hsync_out), 32'(p1_hs));
    check("vsync_out", 32'(vid.vsync_out), 32'(p1_vs));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("done", 32'(done), 32'(m_state == 2 && tick && m_hold == HOLD_FRAMES - 1));
    if (rst) begin
      model_reset();
    end else begin
      lit = p0_in && rom[p0_addr][p0_col] && m_visible() && p0_von;
      p1_text = lit;
      p1_rgb  = lit ? FG : (p0_von ? BG : 12'h000);
      p1_hs = p0_hs; p1_vs = p0_vs;
      p0_in   = (x >= m_pos) && (x < m_pos + 64) && (y >= POS_Y) && (y < POS_Y + 32);
      p0_addr = p0_in ? y - POS_Y : 0;
      p0_col  = (x - m_pos) & 63;
      p0_von = von; p0_hs = hs; p0_vs = vs;
      case (m_state)
        0: if (st) m_state = 1;
        1: if (tick) begin
          m_pos = (m_pos + SLIDE_STEP >= TARGET_X) ? TARGET_X : m_pos + SLIDE_STEP;
          if (m_pos == TARGET_X) begin m_state = 2; m_hold = 0; end
        end
        default: if (tick) begin
          if (m_hold == HOLD_FRAMES - 1) begin m_state = 0; m_pos = START_X; end
          else m_hold++;
        end
      endcase
    end
  endtask

  // Half the pixels land near the banner so edges and lit bits get exercised.
  task automatic rnd(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        x = m_pos - 2 + int'($urandom_range(67, 0));
        if (x < 0) x = 0;
        y = POS_Y - 2 + int'($urandom_range(35, 0));
      end else begin
        x = int'($urandom_range(639, 0));
        y = int'($urandom_range(479, 0));
      end
      cyc(x, y, $urandom_range(7, 0) != 0, 1'($urandom_range(1, 0)),
          1'($urandom_range(1, 0)), 1'b0, 1'b0);
    end
  endtask

  task automatic frame(input int n);
    rnd(n);
    cyc(0, V_ACTIVE, 1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    for (int r = 0; r < 32; r++) rom[r] = {$urandom(), $urandom()};
    rom[0][1] = 1'b1;
    rom[5][0] = 1'b1;
    model_reset();
    reset = 1'b1; start = 1'b0;
    vid.pixel_x = '0; vid.pixel_y = '0; vid.video_on = 1'b0;
    vid.hsync_in = 1'b0; vid.vsync_in = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 3; i++) cyc(i * 10, 230, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    rnd(20);

    // Start, then one in-box pixel at pos_x=0 with a known-lit ROM bit.
    cyc(400, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(START_X + 1, POS_Y, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("dir_addr", 32'(vid.drom_addr_num), 32'd0);
    cyc(700, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("dir_text_on", 32'(vid.text_on), 32'd1);
    check("dir_rgb", 32'(vid.rgb_out), 32'hFFF);
    check("dir_hsync", 32'(vid.hsync_out), 32'd1);

    for (int f = 1; f <= 36; f++) frame(12);
    @(posedge clk); #1;
    check("hold_busy", 32'(busy), 32'd1);

    // Banner now sits at TARGET_X: left column lit, one left / one past right dark.
    cyc(TARGET_X, POS_Y + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(TARGET_X - 1, POS_Y + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pos_left_lit", 32'(vid.text_on), 32'd1);
    cyc(TARGET_X + 64, POS_Y + 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pos_left_dark", 32'(vid.text_on), 32'd0);
    cyc(500, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pos_right_dark", 32'(vid.text_on), 32'd0);

    for (int f = 1; f <= HOLD_FRAMES; f++) begin
      if (f == 50) cyc(300, 300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(12);
    end
    check("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("done_clear", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    rnd(10);

    // Restart and reset mid-slide at pos_x=144.
    cyc(100, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 18; f++) frame(12);
    rnd(6);
    cyc(TARGET_X / 2, POS_Y + 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_text_on", 32'(vid.text_on), 32'd0);
    check("rst_rgb", 32'(vid.rgb_out), 32'd0);
    check("rst_hsync", 32'(vid.hsync_out), 32'd0);
    rnd(10);
    cyc(100, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int f = 1; f <= 3; f++) frame(12);
    rnd(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
